// File: rtl/series_accumulator.sv
// Purpose : power-series evaluator; sums coeff[k] * x^k over NUM_TERMS terms
//           supplied by an external term counter and coefficient ROM.
// Latency : result_valid NUM_TERMS+3 cycles after start is sampled; one term per cycle.
// Backpr. : none; start is accepted only in IDLE and is otherwise dropped.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, x_in             evaluation request and argument (sampled on accept)
//   start_cntr              one-cycle pulse launching the term counter
//   coeff_rd_en, term_cnt   ROM read strobe and term index from the counter
//   coeff_data              ROM data, valid one cycle after its read
//   done                    one-cycle pulse stopping the counter
//   busy                    high from accepted start through result_valid
//   result, result_valid    series sum (held) and its update pulse
//
// Build option: define SERIES_ACC_SAT_EN to saturate the accumulator, the
// running power and the narrowed result; otherwise all arithmetic wraps.
module series_accumulator #(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 12,
  parameter int CNTR_DEPTH = 5,
  parameter int NUM_TERMS  = 8,
  parameter int GUARD_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     x_in,
  output logic                  start_cntr,
  input  logic                  coeff_rd_en,
  input  logic [CNTR_DEPTH-1:0] term_cnt,
  input  logic [DATA_W-1:0]     coeff_data,
  output logic                  done,
  output logic                  busy,
  output logic [DATA_W-1:0]     result,
  output logic                  result_valid
);

  localparam int ACC_W = DATA_W + GUARD_W;
  localparam int PW    = 2 * DATA_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1 << FRAC_W);

  logic [2:0]               state;
  logic signed [DATA_W-1:0] x_reg;
  logic signed [DATA_W-1:0] power;
  logic signed [DATA_W-1:0] power_nxt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic [DATA_W-1:0]        result_nxt;
  logic                     rd_vld_d;
  logic                     rd_hit;
  logic                     done_hit;

  // Full-precision fixed-point multiply: sign-extend both operands to PW
  // bits so no product bits are lost before the arithmetic shift.
  function automatic logic signed [PW-1:0] mul_fx(input logic signed [DATA_W-1:0] a,
                                                  input logic signed [DATA_W-1:0] b);
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    ae = {{(PW-DATA_W){a[DATA_W-1]}}, a};
    be = {{(PW-DATA_W){b[DATA_W-1]}}, b};
    return (ae * be) >>> FRAC_W;
  endfunction

  assign rd_hit   = coeff_rd_en && (term_cnt < CNTR_DEPTH'(NUM_TERMS));
  assign done_hit = coeff_rd_en && (term_cnt == CNTR_DEPTH'(NUM_TERMS - 2));

  assign start_cntr   = (state == S_ARM);
  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_DONE);

`ifdef SERIES_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] DAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] pw_full;
  logic signed [PW:0]   acc_sum;

  // A value fits the narrower range when every bit above its sign bit
  // agrees with the sign; otherwise clamp toward the sign.
  always_comb begin
    prod      = mul_fx($signed(coeff_data), power);
    pw_full   = mul_fx(power, x_reg);
    acc_sum   = {{(PW+1-ACC_W){acc[ACC_W-1]}}, acc} + {prod[PW-1], prod};
    acc_nxt   = acc;
    power_nxt = power;
    if (rd_vld_d) begin
      if (acc_sum[PW:ACC_W-1] == {(PW-ACC_W+2){acc_sum[PW]}})
        acc_nxt = acc_sum[ACC_W-1:0];
      else
        acc_nxt = acc_sum[PW] ? ACC_MIN : ACC_MAX;
      if (pw_full[PW-1:DATA_W-1] == {(PW-DATA_W+1){pw_full[PW-1]}})
        power_nxt = pw_full[DATA_W-1:0];
      else
        power_nxt = pw_full[PW-1] ? DAT_MIN : DAT_MAX;
    end
  end

  always_comb begin
    if (acc_nxt[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){acc_nxt[ACC_W-1]}})
      result_nxt = acc_nxt[DATA_W-1:0];
    else
      result_nxt = acc_nxt[ACC_W-1] ? DAT_MIN : DAT_MAX;
  end
`else
  // Two's-complement wrap: truncating the product to ACC_W bits before the
  // add gives the same result modulo 2^ACC_W as a full-width add.
  always_comb begin
    acc_nxt   = acc;
    power_nxt = power;
    if (rd_vld_d) begin
      acc_nxt   = acc + ACC_W'(mul_fx($signed(coeff_data), power));
      power_nxt = DATA_W'(mul_fx(power, x_reg));
    end
  end

  always_comb begin
    result_nxt = acc_nxt[DATA_W-1:0];
  end
`endif

  // The ROM answers one cycle after the read, so only the valid flag is
  // delayed; terms arrive in order and the delayed index would not change
  // what is accumulated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      x_reg    <= '0;
      power    <= '0;
      acc      <= '0;
      result   <= '0;
      done     <= 1'b0;
      rd_vld_d <= 1'b0;
    end else begin
      rd_vld_d <= (state == S_RUN) && rd_hit;
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_reg <= $signed(x_in);
            state <= S_ARM;
          end
        end
        S_ARM: begin
          power <= ONE;
          acc   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          acc   <= acc_nxt;
          power <= power_nxt;
          // done is high while the last term is read; the following edge
          // moves on so the final product can still land in DRAIN.
          done  <= done_hit;
          if (done)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          acc    <= acc_nxt;
          power  <= power_nxt;
          done   <= 1'b0;
          // Load from acc_nxt so result is visible with result_valid.
          result <= result_nxt;
          state  <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
